// File: rtl/debug_sevenseg_scan.sv
// Eight-digit multiplexed common-anode seven-segment driver with a double-buffered
// display word that is committed only at frame boundaries.
module debug_sevenseg_scan #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] din,
  input  logic [7:0]  dp_in,
  input  logic        load,
  input  logic        en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [31:0]   pend_word_q, pend_word_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   shadow_word_q, shadow_word_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          term_cnt;
  logic          frame_bnd;
  logic [31:0]   upper_bits;
  logic [3:0]    cur_nibble;
  logic          digit_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A disabled display counts as permanently at a frame boundary so pending words commit.
  always_comb begin
    term_cnt  = en && (presc_q == PRESC_MAX);
    frame_bnd = !en || (term_cnt && (idx_q == 3'd7));
  end

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!en) begin
      presc_d = '0;
      idx_d   = 3'd0;
    end else if (term_cnt) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // A load landing on the boundary itself bypasses the pending buffer.
  always_comb begin
    pend_word_d   = pend_word_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    shadow_word_d = shadow_word_q;
    shadow_dp_d   = shadow_dp_q;
    if (load) begin
      pend_word_d  = din;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (frame_bnd) begin
      if (load) begin
        shadow_word_d = din;
        shadow_dp_d   = dp_in;
        pend_valid_d  = 1'b0;
      end else if (pend_valid_q) begin
        shadow_word_d = pend_word_q;
        shadow_dp_d   = pend_dp_q;
        pend_valid_d  = 1'b0;
      end
    end
  end

  always_comb begin
    upper_bits  = shadow_word_q >> {idx_q, 2'b00};
    cur_nibble  = upper_bits[3:0];
    digit_blank = BLANK_LEADING && (idx_q != 3'd0) && (upper_bits == 32'd0);
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !digit_blank) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = hex_to_seg(cur_nibble);
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pend_word_q   <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      shadow_word_q <= '0;
      shadow_dp_q   <= '0;
      presc_q       <= '0;
      idx_q         <= 3'd0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      pend_word_q   <= pend_word_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      shadow_word_q <= shadow_word_d;
      shadow_dp_q   <= shadow_dp_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_debug_sevenseg_scan.sv
// Randomized and directed bench for debug_sevenseg_scan against a frame-position reference model,
// with one instance blanking leading zeros and one showing every digit.
module tb_debug_sevenseg_scan;

   localparam int RD    = 4;
   localparam int FRAME = 8 * RD;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        en;
   logic [31:0] din;
   logic [7:0]  dp_in;
   logic [7:0]  an, anNb;
   logic [6:0]  seg, segNb;
   logic        dp, dpNb;
   logic [2:0]  digitIdx, digitIdxNb;

   int checks = 0;
   int errors = 0;

   logic [6:0]  hexTab [16];

   logic [31:0] mPend, mShadow;
   logic [7:0]  mPdp, mSdp;
   logic        mPvalid;
   int          mPos;
   logic [7:0]  eAn, eAnNb;
   logic [6:0]  eSeg, eSegNb;
   logic        eDp, eDpNb;
   logic        eBlank;

   always #5 clk = ~clk;

   debug_sevenseg_scan #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .Rst(rst), .din(din), .dp_in(dp_in), .load(load), .en(en),
      .an(an), .seg(seg), .dp(dp), .digit_idx(digitIdx)
   );

   debug_sevenseg_scan #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dutNb (
      .clk(clk), .Rst(rst), .din(din), .dp_in(dp_in), .load(load), .en(en),
      .an(anNb), .seg(segNb), .dp(dpNb), .digit_idx(digitIdxNb)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPend = '0; mPdp = '0; mPvalid = 1'b0;
      mShadow = '0; mSdp = '0; mPos = 0;
      eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1;
      eAnNb = 8'hFF; eSegNb = 7'h7F; eDpNb = 1'b1;
      eBlank = 1'b0;
   endtask

   // Reference: the scan is a position 0..FRAME-1 in the frame, digit = position / RD.
   task automatic modelEdge();
      int k;
      logic [31:0] up;
      logic boundary;
      if (rst) begin
         modelReset();
      end else begin
         k = mPos / RD;
         if (en) begin
            up     = mShadow >> (4 * k);
            eBlank = (k != 0) && (up == 32'd0);
            eAnNb  = ~(8'h01 << k);
            eSegNb = hexTab[up[3:0]];
            eDpNb  = ~mSdp[k];
            eAn    = eBlank ? 8'hFF : eAnNb;
            eSeg   = eSegNb;
            eDp    = eBlank ? 1'b1 : eDpNb;
         end else begin
            eBlank = 1'b0;
            eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1;
            eAnNb = 8'hFF; eSegNb = 7'h7F; eDpNb = 1'b1;
         end
         boundary = !en || (mPos == FRAME - 1);
         if (boundary) begin
            if (load) begin
               mShadow = din; mSdp = dp_in;
            end else if (mPvalid) begin
               mShadow = mPend; mSdp = mPdp;
            end
            mPvalid = 1'b0;
         end
         if (load) begin
            mPend = din; mPdp = dp_in;
            if (!boundary) mPvalid = 1'b1;
         end
         mPos = en ? (mPos + 1) % FRAME : 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("an", an, eAn);
      if (!eBlank) checkOutput("seg", seg, eSeg);
      checkOutput("dp", dp, eDp);
      checkOutput("an_nb", anNb, eAnNb);
      checkOutput("seg_nb", segNb, eSegNb);
      checkOutput("dp_nb", dpNb, eDpNb);
      checkOutput("digit_idx", digitIdx, mPos / RD);
      checkOutput("digit_idx_nb", digitIdxNb, mPos / RD);
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic applyStimulus(input logic l, input logic [31:0] d, input logic [7:0] p, input logic e);
      load = l; din = d; dp_in = p; en = e;
      tick();
      load = 1'b0;
   endtask

   task automatic idle(input int n, input logic e);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom, 8'($urandom), e);
   endtask

   task automatic waitPos(input int target);
      int n = 0;
      while (mPos != target && n < 2 * FRAME) begin
         applyStimulus(1'b0, $urandom, 8'($urandom), 1'b1);
         n++;
      end
      if (mPos != target) checkOutput("wait_timeout", 32'(mPos), 32'(target));
   endtask

   // Reset asserted between edges must clear the outputs before any clock edge.
   task automatic asyncReset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_an", an, 8'hFF);
      checkOutput("async_seg", seg, 7'h7F);
      checkOutput("async_dp", dp, 1'b1);
      checkOutput("async_idx", digitIdx, 3'd0);
      modelReset();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      hexTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      modelReset();
      rst = 1'b1; load = 1'b0; en = 1'b1; din = '0; dp_in = '0;
      #1;
      checkOutput("reset_an", an, 8'hFF);
      checkOutput("reset_seg", seg, 7'h7F);
      checkOutput("reset_dp", dp, 1'b1);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("first_seg", seg, 7'h40);
      checkOutput("first_an", an, 8'hFE);
      idle(FRAME, 1'b1);

      // Mid-frame load, visible only after the wrap.
      waitPos(3 * RD);
      applyStimulus(1'b1, 32'h8F100000, 8'h01, 1'b1);
      idle(2 * FRAME, 1'b1);

      // Leading-zero blanking on one instance, all digits lit on the other.
      waitPos(RD + 2);
      applyStimulus(1'b1, 32'h00000100, 8'hFF, 1'b1);
      idle(2 * FRAME, 1'b1);

      // Newest pending word wins, then a load exactly on the boundary cycle.
      waitPos(RD);
      applyStimulus(1'b1, 32'h11111111, 8'h00, 1'b1);
      idle(3, 1'b1);
      applyStimulus(1'b1, 32'h22222222, 8'h00, 1'b1);
      idle(2 * FRAME, 1'b1);
      waitPos(FRAME - 1);
      applyStimulus(1'b1, 32'h33333333, 8'h00, 1'b1);
      idle(FRAME + 2, 1'b1);

      // Enable gating and load while disabled.
      waitPos(5 * RD + 1);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("disable_an", an, 8'hFF);
      applyStimulus(1'b1, 32'h0000000A, 8'h00, 1'b0);
      idle(3, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("enable_seg", seg, 7'h08);
      checkOutput("enable_idx", digitIdx, 3'd0);
      idle(FRAME, 1'b1);

      // Asynchronous reset with a pending load that must be discarded.
      waitPos(6 * RD + 1);
      applyStimulus(1'b1, 32'hDEADBEEF, 8'hFF, 1'b1);
      asyncReset();
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("post_reset_seg", seg, 7'h40);
      idle(FRAME, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 8) == 0, $urandom >> ($urandom % 33), 8'($urandom),
                       ($urandom % 16) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_sevenseg_scan.md
# debug_sevenseg_scan

Multiplexed 8-digit seven-segment driver sitting directly downstream of the debug display FIFO. It consumes the 32-bit word the FIFO presents on the MMIO bus `disp_out` field and shows it as 8 hex digits on common-anode displays. A refresh prescaler scans the digits. New words are double-buffered and take effect only at a frame boundary, so a digit scan never mixes two words. Optional leading-zero blanking and a per-digit decimal-point mask are provided.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Must be ≥ 2. Frame length is 8·REFRESH_DIV.
- `BLANK_LEADING`, default 1: if 1, leading zero digits are blanked. Digit 0 is never blanked.
- `clk` in 1: system clock, the same clock as the MMIO bus.
- `Rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `din` in 32: word to display, driven from `disp_out`. Nibble k, `din[4k+3:4k]`, maps to digit k.
- `dp_in` in 8: decimal-point mask. Bit k=1 lights the DP of digit k.
- `load` in 1: single-cycle request to capture `din`/`dp_in`. Holding it high captures on every cycle.
- `en` in 1: display enable.
- `an` out 8: anode selects, active-low. `an[k]`=0 lights digit k.
- `seg` out 7: cathodes, active-low. `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: decimal-point cathode, active-low.
- `digit_idx` out 3: digit currently being scanned.

## Operation
- Registers:
  - `pend_word`/`pend_dp`/`pend_valid`: pending buffer.
  - `shadow_word`/`shadow_dp`: displayed word.
  - `presc`: 0..REFRESH_DIV-1.
  - `idx`: 0..7, drives `digit_idx`.
- Load: when `load`=1, `pend_word`←`din`, `pend_dp`←`dp_in`, `pend_valid`←1. A later load before the boundary overwrites the pending buffer; the newest word wins.
- Scan, when `en`=1:
  - `presc` increments each cycle.
  - At terminal count (`presc`=REFRESH_DIV-1), `presc`←0 and `idx`←`idx`+1, wrapping 7→0.
- Frame boundary: the terminal-count cycle with `idx`=7.
  - If `load`=1 in that cycle, the shadow takes `din`/`dp_in` directly and `pend_valid`←0.
  - Else if `pend_valid`=1, the shadow takes the pending buffer and `pend_valid`←0.
  - Else the shadow is unchanged.
- Disable: when `en`=0, `presc`←0 and `idx`←0. Every `en`=0 cycle is also treated as a frame boundary, so a pending word is committed. Loads still update the pending buffer.
- Hex decode, active-low `seg[6:0]`:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78
  - 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E
- Blanking: digit k (k≥1) is blank when BLANK_LEADING=1 and shadow nibbles 7..k are all zero.
  - A blank digit drives `an[k]`=1 while selected.
  - DP is also suppressed on a blank digit.
- Selected digit drives `an`=~(1<<idx), `seg`=decode(nibble idx) and `dp`=~`shadow_dp[idx]`.

## Timing
- `an`, `seg` and `dp` are registered and reflect `idx`/shadow with one cycle of latency. `digit_idx` is combinational from `idx`.
- Reset values:
  - `an`=0xFF, `seg`=0x7F, `dp`=1, `digit_idx`=0.
  - `shadow_word`=0, `shadow_dp`=0, `pend_valid`=0, `presc`=0.
- Asynchronous reset: `Rst` clears all registers immediately, without a clock edge, including mid-frame. A pending load is lost.
- `en` falling: `an`=0xFF, `seg`=0x7F and `dp`=1 on the next edge.
- `en` rising: scan starts at digit 0, and the first digit stays lit a full REFRESH_DIV cycles.
- Load-to-display latency:
  - With `en`=1: ≤ 8·REFRESH_DIV + 1 cycles.
  - With `en`=0: the word is visible one cycle after `en` rises.
- Each digit is lit for exactly REFRESH_DIV cycles. There are no glitch cycles between digits beyond the 1-cycle output register alignment.

## Test plan
All scenarios use REFRESH_DIV=4 and BLANK_LEADING=1 unless stated.
1. Reset behaviour:
   - Hold `Rst`, then release with `en`=1 and no load.
   - Outputs are 0xFF/0x7F/1 during reset.
   - Afterwards, digit 0 shows `seg`=0x40 with `an`=0xFE, and digits 1..7 keep their anode high.
2. Load a word mid-frame:
   - Pulse `load` with `din`=0x8F100000 and `dp_in`=0x01 at `idx`=3.
   - The display is unchanged until the frame wraps.
   - Next frame, digits 7..4 show 0x00/0x0E/0x79/0x40, digits 3..0 show 0x40, and digit 0 has `dp`=0.
3. Leading-zero blanking:
   - With `din`=0x00000100, digits 7..3 stay blank, digit 2 shows 0x79, and digits 1..0 show 0x40.
   - With BLANK_LEADING=0, all 8 digits are lit.
4. Newest word wins:
   - Load 0x11111111, then 0x22222222 before the boundary; all digits show 0x24.
   - Load 0x33333333 exactly on the boundary cycle; the next frame shows 0x30.
5. Enable gating:
   - Drop `en` at `idx`=5: `an`=0xFF on the next edge.
   - Load 0x0000000A while disabled, then raise `en`: digit 0 shows 0x08 one cycle later and `digit_idx` restarts at 0.
6. Asynchronous reset mid-frame:
   - Assert `Rst` between clock edges at `idx`=6 with a pending load.
   - Outputs go to reset values before the next edge.
   - After release, the pending word is not displayed and digit 0 shows 0x40.
